// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - 4-digit seven-segment scan controller with tear-free value update
//
// Purpose:
//   Holds a 16-bit hex value and presents one nibble at a time to a downstream
//   seven_seg_decoder. It also drives the matching active-low anode for a
//   common-anode 4-digit display. New values are buffered and swapped in only
//   at frame boundaries, so one frame never mixes old and new digits.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   synchronous active-low reset
//   en        in   1   scan enable; 0 blanks all anodes and freezes the scan
//   load      in   1   one-cycle strobe; value is captured on the same edge
//   value     in  16   four hex digits, digit 0 = value[3:0] (rightmost)
//   blank_lz  in   1   1 = suppress leading zeros (registered before use)
//   nibble    out  4   hex digit of the active slot, {x3,x2,x1,x0}
//   an        out  4   active-low anodes, an[i]=0 lights digit i
//   load_ack  out  1   pulse on the cycle after an accepted load
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot, must be >= 2

module seven_seg_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        load_ack
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_disp;
  logic [15:0]      r_pend;
  logic             r_pend_v;
  logic             r_load_ack;
  // blank_lz is registered so that every output comes from state, with en
  // as the only input that reaches an output combinationally.
  logic             r_blank_lz;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic w_slot_end;   // last cycle of the current digit slot
  logic w_wrap;       // this edge moves idx from 3 back to 0

  assign w_slot_end = en && (r_div_cnt == DIV_MAX);
  assign w_wrap     = w_slot_end && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
    end else if (en) begin
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_idx     <= r_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Value buffering
  //   A load on the wrap edge goes straight to the display register and
  //   discards any older pending value. Any other load parks in r_pend;
  //   the newest one wins and is applied on the next wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp   <= 16'h0000;
      r_pend   <= 16'h0000;
      r_pend_v <= 1'b0;
    end else begin
      if (load && w_wrap) begin
        r_disp   <= value;
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend   <= value;
        r_pend_v <= 1'b1;
      end else if (w_wrap && r_pend_v) begin
        r_disp   <= r_pend;
        r_pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_ack <= 1'b0;
      r_blank_lz <= 1'b0;
    end else begin
      r_load_ack <= load;
      r_blank_lz <= blank_lz;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic [3:0] w_nibble;
  logic [3:0] w_an_sel;
  logic       w_lead_zero;  // active digit and every digit above it are zero

  always_comb begin
    w_nibble    = r_disp[3:0];
    w_an_sel    = 4'b1110;
    w_lead_zero = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nibble    = r_disp[3:0];
        w_an_sel    = 4'b1110;
        w_lead_zero = 1'b0;  // digit 0 always shows, so zero reads "0"
      end
      2'd1: begin
        w_nibble    = r_disp[7:4];
        w_an_sel    = 4'b1101;
        w_lead_zero = (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble    = r_disp[11:8];
        w_an_sel    = 4'b1011;
        w_lead_zero = (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_nibble    = r_disp[15:12];
        w_an_sel    = 4'b0111;
        w_lead_zero = (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  // Blanking only releases the anode; the nibble still carries the digit.
  assign nibble   = w_nibble;
  assign an       = (!en || (r_blank_lz && w_lead_zero)) ? 4'b1111 : w_an_sel;
  assign load_ack = r_load_ack;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan with REFRESH_DIV=4

module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        load_ack;

  always #5 clk = ~clk;

  seven_seg_scan #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .nibble   (nibble),
    .an       (an),
    .load_ack (load_ack)
  );

  typedef struct packed {
    int         id;
    logic [3:0] nib;
    logic [3:0] an;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   push_id = 0;

  // Per-frame displayed value and hand-derived anode pattern per slot
  // (slot s anode = FR_AN[f][4*s +: 4]).
  logic [15:0] FR_VAL [7];
  logic [15:0] FR_AN  [7];

  // Monitor: pop and compare once per cycle whenever an expectation is queued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec_cnt++;
      if (nibble !== e.nib || an !== e.an || load_ack !== e.ack) begin
        err_cnt++;
        $display("FAIL vec%0d: got nibble=%h an=%b ack=%b, want nibble=%h an=%b ack=%b",
                 e.id, nibble, an, load_ack, e.nib, e.an, e.ack);
      end
    end
  end

  // Wait one edge, drive inputs for the next edge, and queue the outputs
  // expected for the state reached on that edge (en is seen combinationally).
  task automatic cyc(input logic r, input logic e_i, input logic ld,
                     input logic [15:0] val, input logic bz,
                     input logic [3:0] enib, input logic [3:0] ean, input logic eack);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n    = r;
    en       = e_i;
    load     = ld;
    value    = val;
    blank_lz = bz;
    x.id  = push_id;
    x.nib = enib;
    x.an  = ean;
    x.ack = eack;
    push_id++;
    exp_q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  AN_ONE [4];
    logic [15:0] fv;
    logic [15:0] fa;
    logic        ld;
    logic [15:0] lv;
    logic        bz;
    logic        eack;
    logic        e_i;
    logic        r;
    logic [3:0]  enib;
    logic [3:0]  ean;
    int          f;
    int          s;

    AN_ONE[0] = 4'b1110; AN_ONE[1] = 4'b1101;
    AN_ONE[2] = 4'b1011; AN_ONE[3] = 4'b0111;

    FR_VAL[0] = 16'h1234; FR_AN[0] = 16'h7BDE;
    FR_VAL[1] = 16'h1234; FR_AN[1] = 16'h7BDE;
    FR_VAL[2] = 16'hABCD; FR_AN[2] = 16'h7BDE;
    FR_VAL[3] = 16'h2222; FR_AN[3] = 16'h7BDE;
    FR_VAL[4] = 16'h0050; FR_AN[4] = 16'hFFDE;  // slots 3,2 blanked
    FR_VAL[5] = 16'h0050; FR_AN[5] = 16'h7BDE;  // blanking off
    FR_VAL[6] = 16'h0000; FR_AN[6] = 16'hFFFE;  // only digit 0 lit

    // Reset held for two edges with load asserted.
    rst_n = 1'b0; en = 1'b1; load = 1'b1; value = 16'hFFFF; blank_lz = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4'h0, 4'b1110, 1'b0);

    // First frame after reset: disp=0, all four digits lit; the last cycle
    // loads 16'h1234 on the wrap edge. load_ack must stay 0 after reset.
    for (int n = 0; n < 16; n++) begin
      cyc(1'b1, 1'b1, (n == 15), 16'h1234, 1'b0, 4'h0, AN_ONE[n / 4], 1'b0);
    end

    // Frames 0..6 measured from the wrap that applied 16'h1234.
    for (int m = 0; m < 112; m++) begin
      f  = m / 16;
      s  = (m / 4) % 4;
      fv = FR_VAL[f];
      fa = FR_AN[f];
      ld = 1'b0;
      lv = 16'h0000;
      case (m)
        24:  begin ld = 1'b1; lv = 16'hABCD; end  // mid-frame, idx=2
        36:  begin ld = 1'b1; lv = 16'h1111; end
        40:  begin ld = 1'b1; lv = 16'h2222; end  // overwrites 1111
        63:  begin ld = 1'b1; lv = 16'h0050; end  // on wrap edge
        95:  begin ld = 1'b1; lv = 16'h0000; end  // on wrap edge
        111: begin ld = 1'b1; lv = 16'h1234; end  // on wrap edge
        default: ;
      endcase
      bz   = ((m >= 63) && (m < 79)) || (m >= 95);
      eack = (m == 0) || (m == 25) || (m == 37) || (m == 41) ||
             (m == 64) || (m == 96);
      cyc(1'b1, 1'b1, ld, lv, bz, fv[4*s +: 4], fa[4*s +: 4], eack);
    end

    // Freeze at idx=1, resume, then reset mid-slot at idx=2.
    for (int m = 112; m <= 136; m++) begin
      e_i  = !((m >= 117) && (m <= 126));
      r    = (m != 131);
      eack = (m == 112);
      if (m <= 115)      begin enib = 4'h4; ean = 4'b1110; end
      else if (m == 116) begin enib = 4'h3; ean = 4'b1101; end
      else if (m <= 126) begin enib = 4'h3; ean = 4'b1111; end
      else if (m <= 129) begin enib = 4'h3; ean = 4'b1101; end
      else if (m <= 131) begin enib = 4'h2; ean = 4'b1011; end
      else if (m <= 135) begin enib = 4'h0; ean = 4'b1110; end
      else               begin enib = 4'h0; ean = 4'b1101; end
      cyc(r, e_i, 1'b0, 16'h0000, 1'b0, enib, ean, eack);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
